// File: rtl/img2col_window_loader.sv
// img2col window loader: streams 5x5 image windows from a row-major image memory into a
// column-major window register file and hands each window to a downstream processor.
// Round 0 of each window row loads all 25 pixels; each later round loads only the new
// rightmost column into addresses 20..24.
module img2col_window_loader #(
    parameter int unsigned data_width  = 16,
    parameter int unsigned address_num = 5,
    parameter int unsigned img_w       = 28,
    parameter int unsigned img_h       = 28,
    parameter int unsigned mem_aw      = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_start,
    output logic                   mem_ren,
    output logic [mem_aw-1:0]      mem_raddr,
    input  logic [data_width-1:0]  mem_rdata,
    output logic                   wr_ctrl_g,
    output logic [address_num-1:0] adrs_in1,
    output logic [data_width-1:0]  wdata_g,
    output logic                   start,
    output logic [5:0]             round,
    input  logic                   r_ctrl_g,
    output logic                   busy,
    output logic                   frame_done
);

    localparam int unsigned WrW = (img_h > 2) ? $clog2(img_h) : 1;

    localparam logic [mem_aw-1:0]      ImgWAddr  = mem_aw'(img_w);
    localparam logic [mem_aw-1:0]      AddrOne   = mem_aw'(1);
    localparam logic [5:0]             LastRound = 6'(img_w - 5);
    localparam logic [WrW-1:0]         LastWr    = WrW'(img_h - 5);
    localparam logic [address_num-1:0] LastTgt   = address_num'(24);
    localparam logic [address_num-1:0] ColTgt    = address_num'(20);
    localparam logic [address_num-1:0] TgtOne    = address_num'(1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StFetch,
        StWaitPu,
        StDone
    } state_e;

    state_e                 state_q;
    logic [WrW-1:0]         wr_q;
    logic [5:0]             round_q;
    logic [2:0]             row_q;
    logic [mem_aw-1:0]      row_base_q;  // address of pixel (wr, 0)
    logic [mem_aw-1:0]      top_q;       // address of the top pixel of the column being read
    logic [mem_aw-1:0]      raddr_q;
    logic                   ren_q;
    logic [address_num-1:0] tgt_q;       // window address of the read issued this cycle
    logic [address_num-1:0] adrs_q;
    logic                   wr_ctrl_q;
    logic [data_width-1:0]  wdata_q;
    logic                   start_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   seen_hi_q;

    logic [mem_aw-1:0] top_next;
    logic [mem_aw-1:0] base_next;

    // Running-adder address steps: next column top and next window-row base
    always_comb begin
        top_next  = top_q + AddrOne;
        base_next = row_base_q + ImgWAddr;
    end

    // Frame sequencer with registered outputs; read data is written one cycle after its read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            wr_q       <= '0;
            round_q    <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            top_q      <= '0;
            raddr_q    <= '0;
            ren_q      <= 1'b0;
            tgt_q      <= '0;
            adrs_q     <= '0;
            wr_ctrl_q  <= 1'b0;
            wdata_q    <= '0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            seen_hi_q  <= 1'b0;
        end else begin
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            wr_ctrl_q <= 1'b0;
            // Remember the last written pixel so wdata_g holds between writes
            if (wr_ctrl_q) begin
                wdata_q <= mem_rdata;
            end
            unique case (state_q)
                StIdle: begin
                    if (frame_start) begin
                        state_q    <= StStart;
                        start_q    <= 1'b1;
                        busy_q     <= 1'b1;
                        wr_q       <= '0;
                        round_q    <= '0;
                        row_base_q <= '0;
                    end
                end
                StStart: begin
                    state_q <= StFetch;
                    ren_q   <= 1'b1;
                    raddr_q <= row_base_q;
                    top_q   <= row_base_q;
                    row_q   <= '0;
                    tgt_q   <= '0;
                end
                StFetch: begin
                    wr_ctrl_q <= 1'b1;
                    adrs_q    <= tgt_q;
                    // Both round kinds end on window address 24
                    if (tgt_q == LastTgt) begin
                        ren_q     <= 1'b0;
                        seen_hi_q <= 1'b0;
                        state_q   <= StWaitPu;
                    end else begin
                        tgt_q <= tgt_q + TgtOne;
                        if (row_q == 3'd4) begin
                            row_q   <= '0;
                            raddr_q <= top_next;
                            top_q   <= top_next;
                        end else begin
                            row_q   <= row_q + 3'd1;
                            raddr_q <= raddr_q + ImgWAddr;
                        end
                    end
                end
                StWaitPu: begin
                    // Advance only after the processor has finished reading (high then low)
                    if (r_ctrl_g) begin
                        seen_hi_q <= 1'b1;
                    end else if (seen_hi_q) begin
                        seen_hi_q <= 1'b0;
                        row_q     <= '0;
                        if (round_q < LastRound) begin
                            round_q <= round_q + 6'd1;
                            state_q <= StFetch;
                            ren_q   <= 1'b1;
                            raddr_q <= top_next;
                            top_q   <= top_next;
                            tgt_q   <= ColTgt;
                        end else if (wr_q < LastWr) begin
                            wr_q       <= wr_q + WrW'(1);
                            round_q    <= '0;
                            row_base_q <= base_next;
                            raddr_q    <= base_next;
                            top_q      <= base_next;
                            tgt_q      <= '0;
                            ren_q      <= 1'b1;
                            state_q    <= StFetch;
                        end else begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Write data passes straight through from memory in the write cycle, held otherwise
    always_comb begin
        mem_ren    = ren_q;
        mem_raddr  = raddr_q;
        wr_ctrl_g  = wr_ctrl_q;
        adrs_in1   = adrs_q;
        wdata_g    = wr_ctrl_q ? mem_rdata : wdata_q;
        start      = start_q;
        round      = round_q;
        busy       = busy_q;
        frame_done = done_q;
    end

endmodule

// File: doc/img2col_window_loader.md
IMG2COL_WINDOW_LOADER -- requirements
Module: img2col_window_loader

Interface
REQ-001 SHALL have parameters: data_width (default 16, pixel width); address_num (default 5, window address width); img_w (default 28, image width in pixels, 6..68); img_h (default 28, image height, >=5); mem_aw (default 10, image memory address width).
REQ-002 SHALL have ports (name direction width meaning):
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous reset, active-high
- frame_start  in  1  request to process one frame
- mem_ren  out  1  image memory read enable
- mem_raddr  out  mem_aw  image memory address, row-major: r*img_w+c
- mem_rdata  in  data_width  read data, valid exactly 1 cycle after mem_ren
- wr_ctrl_g  out  1  window register write strobe
- adrs_in1  out  address_num  window register address, 0..24
- wdata_g  out  data_width  window register write data
- start  out  1  one-cycle pulse that starts the window processor
- round  out  6  window index within current window row
- r_ctrl_g  in  1  window processor read flag, high during its read/reuse phase
- busy  out  1  high from frame_start acceptance until frame_done
- frame_done  out  1  one-cycle pulse after the last window is consumed

Function
REQ-003 SHALL address the 5x5 window column-major: adrs = col*5 + row, col 0 leftmost, row 0 top.
REQ-004 SHALL use FSM states IDLE, START, FETCH, WAIT_PU, DONE.
REQ-005 IDLE: frame_start=1 -> START; busy=1; window row wr=0, round=0. frame_start SHALL be ignored in all other states.
REQ-006 START: start=1 for exactly this one cycle; next state FETCH.
REQ-007 FETCH: mem_ren=1 every cycle, one read per cycle, no bubbles.
- round 0: 25 reads, col 0..4 outer, row 0..4 inner.
- round k>0: 5 reads of image column k+4, rows 0..4.
REQ-008 Read address SHALL be (wr+row)*img_w + (k+col), with k=0 for round 0; it SHALL be computed with running adders, no multipliers or dividers.
REQ-009 For each read issued in cycle t, in cycle t+1: wr_ctrl_g=1, wdata_g=mem_rdata, adrs_in1 = target address. Round 0 targets 0..24; round k>0 targets 20..24.
REQ-010 After the last read issues -> WAIT_PU. The final write (adrs_in1=24) SHALL occur in the first WAIT_PU cycle.
REQ-011 WAIT_PU SHALL wait until r_ctrl_g has been seen high and then low, then advance:
- round < img_w-5: round+1, -> FETCH;
- else if wr < img_h-5: wr+1, round=0, -> FETCH;
- else -> DONE.
REQ-012 round SHALL change only on leaving WAIT_PU, and SHALL stay stable while r_ctrl_g=1.
REQ-013 DONE: frame_done=1 for one cycle, busy=0; next state IDLE.
REQ-014 Outside REQ-009 cycles, wr_ctrl_g=0 and adrs_in1/wdata_g SHALL hold their last values. mem_ren=0 outside FETCH.
REQ-015 Frame totals SHALL be (img_h-4) window rows x [25 + 5*(img_w-5)] writes, and (img_h-4)*(img_w-4) windows.

Reset
REQ-016 rst=1 SHALL force IDLE asynchronously. While rst=1 and on the first cycle after release, all outputs SHALL be 0: mem_ren, mem_raddr, wr_ctrl_g, adrs_in1, wdata_g, start, round, busy, frame_done.
REQ-017 Reset mid-frame SHALL discard the frame, including any in-flight read. A new frame_start SHALL restart at wr=0, round=0.

Verification (img_w=8, img_h=6, memory holds pixel value = address)
REQ-018 Basic write sequence: frame_start at cycle 0 -> start=1 at cycle 1; mem_ren with raddr 0,8,16,24,32,1 in cycles 2..7; writes (adrs,data) = (0,0),(1,8),(2,16),(3,24),(4,32),(5,1) in cycles 3..8.
REQ-019 Handshake hold: after (24,36) is written, hold r_ctrl_g low 10 cycles -> no mem_ren, round=0 held. Pulse r_ctrl_g high 2 cycles then low -> round=1; reads 5,13,21,29,37 written to adrs 20..24.
REQ-020 Window-row wrap: after round 3 is consumed -> round=0, wr=1; first write is (0,8), last write is (24,44).
REQ-021 Frame end: after 8 windows are consumed -> frame_done pulses once; busy falls in the same cycle; total wr_ctrl_g count is 80.
REQ-022 Reset and ignored request: rst asserted during round 1 of wr=0 -> all outputs 0 immediately. frame_start during FETCH -> ignored. frame_start after reset -> first write is (0,0).
